forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_pkg.sv | 24 ++
 rtl/reg_match.sv | 18 +
 rtl/forward_ctrl.sv | 137 +++++++++++++
 tb/tb_forward_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/forward_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard unit.
package forward_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  localparam int unsigned XZR_IDX = 31;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic fwd_sel_t pick_fwd(input logic ex_hit,
                                        input logic mem_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_EXMEM;
    else if (mem_hit)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/reg_match.sv
// Destination/source register comparator; XZR never matches.
module reg_match
  import forward_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] dst_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             wr_i,
  output logic             match_o
);

  logic not_zr;

  assign not_zr  = (dst_i != REG_W'(XZR_IDX));
  assign match_o = wr_i && not_zr && (dst_i == src_i);

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding select and load-use stall for a 5-stage pipeline.
// Optional FORWARD_STATS_EN adds a saturating stall-cycle counter.
module forward_ctrl
  import forward_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`ifdef FORWARD_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             stall
);

  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_wr_q, ex_wr_d;
  logic             ex_ld_q, ex_ld_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  fwd_sel_t         fwd_a_q, fwd_a_d;
  fwd_sel_t         fwd_b_q, fwd_b_d;

  logic ex_ldwr;
  logic ld_hit_a, ld_hit_b;
  logic ex_hit_a, ex_hit_b;
  logic mem_hit_a, mem_hit_b;
  logic bubble;

  assign ex_ldwr = ex_wr_q && ex_ld_q;

  reg_match #(.REG_W(REG_W)) u_ld_a (
    .dst_i(ex_rd_q), .src_i(id_rn),
    .wr_i(ex_ldwr), .match_o(ld_hit_a)
  );

  reg_match #(.REG_W(REG_W)) u_ld_b (
    .dst_i(ex_rd_q), .src_i(id_rm),
    .wr_i(ex_ldwr), .match_o(ld_hit_b)
  );

  reg_match #(.REG_W(REG_W)) u_ex_a (
    .dst_i(ex_rd_q), .src_i(id_rn),
    .wr_i(ex_wr_q), .match_o(ex_hit_a)
  );

  reg_match #(.REG_W(REG_W)) u_ex_b (
    .dst_i(ex_rd_q), .src_i(id_rm),
    .wr_i(ex_wr_q), .match_o(ex_hit_b)
  );

  reg_match #(.REG_W(REG_W)) u_mem_a (
    .dst_i(mem_rd_q), .src_i(id_rn),
    .wr_i(mem_wr_q), .match_o(mem_hit_a)
  );

  reg_match #(.REG_W(REG_W)) u_mem_b (
    .dst_i(mem_rd_q), .src_i(id_rm),
    .wr_i(mem_wr_q), .match_o(mem_hit_b)
  );

  assign stall  = ld_hit_a || ld_hit_b;
  assign bubble = stall || flush;

  always_comb begin
    ex_rd_d  = id_rd;
    ex_wr_d  = id_regwr;
    ex_ld_d  = id_memrd;
    mem_rd_d = ex_rd_q;
    mem_wr_d = ex_wr_q;
    fwd_a_d  = pick_fwd(ex_hit_a, mem_hit_a);
    fwd_b_d  = pick_fwd(ex_hit_b, mem_hit_b);
    // A squashed or held instruction enters EX as a bubble.
    if (bubble) begin
      ex_rd_d = '0;
      ex_wr_d = 1'b0;
      ex_ld_d = 1'b0;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd_q  <= '0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef FORWARD_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  if (CNT_W > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed vector table, reset/flush corners,
// and randomized traffic against an in-flight-instruction model.
module tb_forward_ctrl;

`ifdef FORWARD_STATS_EN
  localparam int CW = 12;
`else
  localparam int CW = 16;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_regwr, id_memrd, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
`ifdef FORWARD_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  forward_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .id_rn(id_rn),
    .id_rm(id_rm),
    .id_rd(id_rd),
    .id_regwr(id_regwr),
    .id_memrd(id_memrd),
    .flush(flush),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
`ifdef FORWARD_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .stall(stall)
  );

  typedef struct {
    string      nm;
    logic [4:0] rn, rm, rd;
    bit         wr, ld, fl;
    bit         st;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         ld;
  } slot_t;

  int n_cmp = 0;
  int n_bad = 0;

  // In-flight instructions, youngest (EX) first.
  slot_t inflight[$];
  longint m_cnt;
  vec_t tbl[$];

  function automatic vec_t mk(string nm, int rn, int rm, int rd,
                              bit wr, bit ld, bit fl,
                              bit st, int fa, int fb);
    vec_t v;
    v.nm = nm;
    v.rn = 5'(rn); v.rm = 5'(rm); v.rd = 5'(rd);
    v.wr = wr; v.ld = ld; v.fl = fl;
    v.st = st; v.fa = 2'(fa); v.fb = 2'(fb);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    slot_t b;
    b = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
    inflight.delete();
    inflight.push_back(b);
    inflight.push_back(b);
    m_cnt = 0;
  endtask

  function automatic bit m_stall(logic [4:0] rn, logic [4:0] rm);
    slot_t s;
    s = inflight[0];
    return s.ld && s.wr && s.rd != 5'd31 && (s.rd == rn || s.rd == rm);
  endfunction

  // Nearest older writer of src supplies the operand.
  function automatic logic [1:0] m_src(logic [4:0] src);
    if (src == 5'd31) return 2'd0;
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].wr && inflight[i].rd == src)
        return (i == 0) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  task automatic apply(input vec_t v, input bit from_tbl);
    bit         mst, est;
    logic [1:0] efa, efb;
    slot_t      s;
    longint     cmax;
    @(negedge clk);
    id_rn = v.rn; id_rm = v.rm; id_rd = v.rd;
    id_regwr = v.wr; id_memrd = v.ld; flush = v.fl;
    #1;
    mst = m_stall(v.rn, v.rm);
    est = mst;
    efa = (mst || v.fl) ? 2'd0 : m_src(v.rn);
    efb = (mst || v.fl) ? 2'd0 : m_src(v.rm);
    if (from_tbl) begin
      est = v.st; efa = v.fa; efb = v.fb;
    end
    chk({v.nm, ".stall"}, 32'(stall), 32'(est));
    s = (mst || v.fl) ? '{rd: 5'd0, wr: 1'b0, ld: 1'b0}
                      : '{rd: v.rd, wr: v.wr, ld: v.ld};
    inflight.push_front(s);
    void'(inflight.pop_back());
    cmax = (longint'(1) << CW) - 1;
    if (mst && m_cnt < cmax) m_cnt++;
    @(posedge clk);
    #1;
    chk({v.nm, ".fwd_a"}, 32'(fwd_a), 32'(efa));
    chk({v.nm, ".fwd_b"}, 32'(fwd_b), 32'(efb));
`ifdef FORWARD_STATS_EN
    chk({v.nm, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  function automatic logic [4:0] rnd_reg();
    int p;
    p = $urandom_range(0, 4);
    return (p == 4) ? 5'd31 : 5'(p);
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl.push_back(mk("add1",     2,  3,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sub_ex",   1,  3,  2, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("nop0",    31, 31, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("nop1",    31, 31, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("add1b",    5,  6,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("nop2",    31, 31, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("orr_wb",   5,  1,  4, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk("nop3",    31, 31, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("nop4",    31, 31, 31, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ldur7",    9, 31,  7, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("lu_stall", 7,  7,  8, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lu_fwd",   7,  7,  8, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk("add31",    2,  3, 31, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("use31",   31, 31, 10, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ldur31",   2, 31, 31, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("use31ld", 31,  2, 11, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("add1c",    2,  3,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("add1d",    4,  5,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("prio",     1,  1,  6, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk("ld_fl",    2, 31,  7, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk("no_st",    7,  7,  8, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ldur7b",   2, 31,  7, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("lu_flush", 7,  3,  8, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk("after_fl", 7,  7,  9, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk("add1e",    2,  3,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("use_fl",   1,  1,  5, 1, 0, 1, 0, 0, 0));

    reset = 1'b1;
    id_rn = '0; id_rm = '0; id_rd = '0;
    id_regwr = 1'b0; id_memrd = 1'b0; flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fwd_a", 32'(fwd_a), 32'd0);
    chk("rst.fwd_b", 32'(fwd_b), 32'd0);
`ifdef FORWARD_STATS_EN
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Reset pulse while a load-use stall is showing.
    apply(mk("mr_ld", 2, 31, 7, 1, 1, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    id_rn = 5'd7; id_rm = 5'd7; id_rd = 5'd8;
    id_regwr = 1'b1; id_memrd = 1'b0; flush = 1'b0;
    #1;
    chk("mr.stall_pre", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr.stall_rst", 32'(stall), 32'd0);
    chk("mr.fwd_a", 32'(fwd_a), 32'd0);
    chk("mr.fwd_b", 32'(fwd_b), 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(mk("mr_post", 7, 7, 8, 1, 0, 0, 0, 0, 0), 1'b1);

    for (int i = 0; i < 3000; i++) begin
      v.nm = "rnd";
      v.rn = rnd_reg(); v.rm = rnd_reg(); v.rd = rnd_reg();
      v.wr = ($urandom_range(0, 3) != 0);
      v.ld = ($urandom_range(0, 2) == 0);
      v.fl = ($urandom_range(0, 7) == 0);
      v.st = 1'b0; v.fa = '0; v.fb = '0;
      apply(v, 1'b0);
    end

`ifdef FORWARD_STATS_EN
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      apply(mk("sat_ld", 2, 31, 7, 1, 1, 0, 0, 0, 0), 1'b0);
      apply(mk("sat_use", 7, 3, 8, 1, 0, 0, 0, 0, 0), 1'b0);
    end
    chk("sat.cnt", 32'(stall_cnt), 32'((1 << CW) - 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
